// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one RAM port between instruction fetch and data access,
// with fixed data priority and a starvation limit that forces a fetch grant.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        iREN,
    input  logic [31:0] iaddr,
    output logic [31:0] iload,
    output logic        iwait,
    input  logic        dREN,
    input  logic        dWEN,
    input  logic [31:0] daddr,
    input  logic [31:0] dstore,
    output logic [31:0] dload,
    output logic        dwait,
    output logic        ramREN,
    output logic        ramWEN,
    output logic [31:0] ramaddr,
    output logic [31:0] ramstore,
    input  logic [31:0] ramload,
    input  logic        ram_ready,
    output logic [1:0]  owner
);
    typedef enum logic [1:0] {IDLE = 2'b00, IGRANT = 2'b01, DGRANT = 2'b10} state_t;

    state_t      state, state_nx;
    logic [3:0]  starve;
    logic        op_wr;
    logic [31:0] addr_r, store_r;
    logic        starved, i_done, d_done;

    assign starved = iREN && (starve == 4'(STARVE_LIMIT));

    always_comb begin
        state_nx = state;
        if (state == IDLE)
            state_nx = ((dREN || dWEN) && !starved) ? DGRANT : (iREN ? IGRANT : IDLE);
        else if (ram_ready)
            state_nx = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            starve  <= '0;
            op_wr   <= 1'b0;
            addr_r  <= '0;
            store_r <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == DGRANT) begin
                addr_r  <= daddr;
                store_r <= dstore;
                op_wr   <= dWEN;
            end
            if (state == IDLE && state_nx == IGRANT) begin
                addr_r  <= iaddr;
                store_r <= '0;
                op_wr   <= 1'b0;
            end
            // IGRANT entry wins over the idle clear; DGRANT entry counts only while fetch waits
            if (state == IDLE && state_nx == IGRANT)
                starve <= '0;
            else if (state == IDLE && state_nx == DGRANT && iREN)
                starve <= starved ? starve : starve + 4'd1;
            else if (state == IDLE && !iREN)
                starve <= '0;
        end
    end

    assign i_done   = (state == IGRANT) && ram_ready;
    assign d_done   = (state == DGRANT) && ram_ready;
    assign iwait    = !i_done;
    assign dwait    = !d_done;
    assign iload    = i_done ? ramload : '0;
    assign dload    = d_done ? ramload : '0;
    assign ramREN   = (state != IDLE) && !op_wr;
    assign ramWEN   = (state != IDLE) && op_wr;
    assign ramaddr  = addr_r;
    assign ramstore = store_r;
    assign owner    = state;
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter sharing one RAM port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the pipelined datapath.
- Arbitrates between requesters and latches the winner's address and store data.
- Drives the RAM until the RAM reports completion, then returns the load data and releases the winner's wait.
- Data has fixed priority over instruction; a starvation limit guarantees forward progress for fetch.

Parameters:
- STARVE_LIMIT, 4: consecutive data grants allowed while iREN is pending before one instruction grant is forced; legal range 1..15.

Ports:
- CLK  in  1  clock, rising-edge
- RST  in  1  synchronous active-high reset
- iREN  in  1  instruction read request
- iaddr  in  32  instruction address
- iload  out  32  instruction read data
- iwait  out  1  1 = instruction access not complete this cycle
- dREN  in  1  data read request
- dWEN  in  1  data write request
- daddr  in  32  data address
- dstore  in  32  data write value
- dload  out  32  data read data
- dwait  out  1  1 = data access not complete this cycle
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data, valid when ram_ready=1
- ram_ready  in  1  RAM access completes this cycle
- owner  out  2  00 = idle, 01 = instruction, 10 = data

Behaviour:
- Reset: RST=1 at a rising edge gives state IDLE, all of the following, effective next cycle:
  - ramREN=0, ramWEN=0, ramaddr=0, ramstore=0
  - owner=00, starve counter=0, latched op/address/data cleared
  - iwait=1, dwait=1
- Reset mid-transaction abandons the access; no wait is released for it.
- FSM states: IDLE, IGRANT, DGRANT.
- IDLE arbitration, evaluated each cycle:
  - if (dREN|dWEN) and not (iREN and starve==STARVE_LIMIT): go to DGRANT.
  - else if iREN: go to IGRANT.
  - else: stay in IDLE.
- On entry to a grant state, capture into registers: address, store data, and op (write if dWEN, else read).
- dREN and dWEN both high is treated as a write.
- In DGRANT and IGRANT:
  - RAM outputs are driven from the captured registers only.
  - ramREN = captured read op; ramWEN = captured write op (instruction op is always read).
  - The state is held while ram_ready=0.
- On ram_ready=1 in a grant state:
  - that cycle, the winner's wait=0 (combinational from ram_ready and state).
  - iload/dload = ramload, passed through combinationally.
  - next state is IDLE (one arbitration bubble between accesses).
- Wait/load outside completion: iwait = not (IGRANT and ram_ready), and likewise for dwait. Waits are 1 in all other cycles, including when no request is asserted. iload/dload are 0 when not completing.
- Starve counter:
  - increments on each DGRANT entry while iREN=1, saturating at STARVE_LIMIT.
  - clears on IGRANT entry, or on any IDLE cycle with iREN=0.
- Requests dropped mid-grant: the RAM access still runs to ram_ready (RAM cannot abort); wait/load still pulse in the completion cycle; the requester ignores them.
- Requester inputs may change during a grant without effect; the captured values are used.
- owner reflects the current state; strobes are low in IDLE and ramaddr/ramstore hold their last values.
- Latency: request at cycle 0 → grant state at cycle 1 → earliest completion (wait=0) at cycle 1 if ram_ready is already high.

Test Plan:
- Reset: RST=1 for 2 cycles with iREN=1 → owner=00, ramREN=0, iwait=1; after release, IGRANT in the next cycle with ramaddr=iaddr.
- Instruction read: iREN=1, iaddr=0x40, ram_ready high 3 cycles after grant with ramload=0x8C220004 → iwait=0 for exactly that cycle, iload=0x8C220004, then IDLE for one cycle.
- Collision: iREN=1 and dREN=1 (daddr=0x100) in the same cycle → DGRANT first with ramaddr=0x100; IGRANT follows after the bubble.
- Write with mid-grant input change: dWEN=1, daddr=0x200, dstore=0xDEADBEEF, with daddr/dstore changed during the grant → ramWEN=1, ramaddr=0x200, ramstore=0xDEADBEEF throughout; dwait=0 only on ram_ready.
- Starvation: iREN held and dREN held, STARVE_LIMIT=4, ram_ready=1 every grant cycle → 4 DGRANTs, 1 IGRANT, repeating; counter reads 0 after the IGRANT.
- Reset mid-transaction: RST asserted 1 cycle into a DGRANT → ramREN/ramWEN=0 next cycle, dwait stays 1, FSM in IDLE; a subsequent request is served normally.
